i2s_tdm_tx: RTL and testbench
=============================

Name: i2s_tdm_tx

Overview:
Parametrised multi-channel I2S/TDM serial transmitter, the next generation of the stereo I2S transmit path. It takes audio words from a local write port into an internal FIFO and serialises them MSB-first. It generates sclk, ws and sd from pclk with a programmable divider. It supports 2-channel I2S and N-slot TDM framing, MSB-justified and Philips standards, and frame-aligned underrun handling.

Parameters:
NUM_CH, 2, channels (slots) per frame, 2..8; 2 = I2S level-ws, >2 = TDM pulse-ws
WORD_W, 32, valid audio bits per word, 16/24/32, must be <= SLOT_W
SLOT_W, 32, sclk periods per slot, 16 or 32
FIFO_DEPTH, 16, words, power of 2, >= NUM_CH
CLK_DIV, 2, pclk cycles per sclk half-period, >= 1

Ports:
pclk  in  1  sole clock
preset  in  1  synchronous reset, active-high
enable  in  1  1 = run; 0 = stop at the next frame boundary
standard  in  1  0 = MSB-justified, 1 = Philips; sampled only in IDLE
wr_en  in  1  push wr_data into FIFO
wr_data  in  32  word in [WORD_W-1:0]; upper bits ignored
full  out  1  FIFO full; wr_en ignored while high
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
clr_underrun  in  1  clears underrun
underrun  out  1  sticky, set when a zero frame is sent
busy  out  1  high in RUN
sclk  out  1  serial clock
ws  out  1  word select / frame sync
sd  out  1  serial data

Behaviour:
- Reset (preset=1 at posedge pclk): sclk=ws=sd=0, busy=0, underrun=0, full=0, level=0, FIFO pointers=0, state=IDLE. Reset mid-frame aborts the frame immediately. FIFO contents are discarded.
- The divider counts 0..CLK_DIV-1 in RUN only and toggles sclk at terminal count.
- A rise tick is the cycle sclk goes 0->1. A fall tick is the cycle sclk goes 1->0. sd and ws change only at a fall tick, or on the IDLE->RUN entry cycle.
- Frame = NUM_CH*SLOT_W bits. The counters are bit_cnt (0..SLOT_W-1) and slot_cnt (0..NUM_CH-1). Both wrap at frame end.
- Slot content: word bits WORD_W-1..0 MSB-first, then SLOT_W-WORD_W zero bits.
- Frame-start decision, made at IDLE entry and at the fall tick ending the last bit of the last slot:
  - If level >= NUM_CH, the frame is "live". One word is popped at the start of each slot, so exactly NUM_CH pops happen per frame.
  - Otherwise the frame is a zero frame: no pops, sd=0 for the whole frame, underrun set.
- ws with NUM_CH=2 and MSB-justified: ws=0 during slot 0 and 1 during slot 1.
- ws with NUM_CH>2 and MSB-justified: ws=1 for exactly the first bit of slot 0, 0 otherwise.
- Philips standard: every ws transition is advanced by one sclk period, so it occurs one bit before the slot/frame MSB. The first frame after IDLE gets the advance by starting ws one bit early during a one-bit lead-in with sd=0.
- FSM:
  - IDLE -> RUN when enable=1. The decision is evaluated in the same cycle. sd shows the MSB, or 0 for a Philips lead-in, on the entry cycle.
  - RUN -> RUN at frame end while enable=1.
  - RUN -> IDLE at frame end when enable=0. In IDLE, sclk=0, ws=0, sd=0.
  - Deasserting enable mid-frame always completes the frame.
- FIFO: push when wr_en & !full. A simultaneous push and pop is allowed and leaves level unchanged. Pointers wrap modulo FIFO_DEPTH. A pop never occurs when empty; the frame-level check guarantees this.
- underrun: set has priority over clr_underrun when both occur in the same cycle.

Optional Feature:
Macro I2S_TDM_FRAME_CNT_EN.
- Defined: adds the output frame_cnt[15:0]. It resets to 0 and increments by 1, wrapping, at each completed frame, live or zero.
- Not defined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- The shared package ctrl_pkg gains enum std_t {MSB, PHILIPS}, the constants W16=16, W24=24, W32=32 and MAX_CH=8.
- One sub-module: i2s_sync_fifo. It is a parametrised width/depth synchronous FIFO with full, empty and level outputs, on the same pclk and synchronous active-high preset.

Test Plan:
1. Reset test: hold preset 3 cycles -> all outputs 0, level=0. wr_en while in reset -> level stays 0.
2. Stereo MSB (NUM_CH=2, WORD_W=SLOT_W=32, CLK_DIV=2): push 32'hA5A50001 then 32'h5A5A0002, set enable -> sd carries those bit streams. ws=0 for 32 sclk, then 1 for 32 sclk. level returns to 0, underrun stays 0.
3. Philips stereo, same words -> each ws edge occurs exactly one sclk before the MSB of each word. The first frame has a 1-bit lead-in with sd=0.
4. TDM (NUM_CH=4, WORD_W=24, SLOT_W=32): push 24'hABCDEF, 24'h123456, 24'h000001, 24'hFFFFFF -> each slot is 24 data bits then 8 zeros. ws is a 1-sclk pulse every 128 sclk.
5. Underrun (NUM_CH=4): push 3 words, enable -> zero frame sent, underrun=1, level=3. Push a 4th word -> the next frame is live with the words in order. clr_underrun -> underrun=0.
6. Full and stop: push FIFO_DEPTH+2 words -> full=1, level=FIFO_DEPTH, extras dropped. Drop enable at bit 10 of slot 1 -> the frame completes, then busy=0 and sclk/ws/sd are held 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the I2S/TDM transmit path: serial standard, FSM states, and the
// word-select pattern as a function of bit position within a frame.
package ctrl_pkg;

  typedef enum logic {MSB, PHILIPS} std_t;
  typedef enum logic {StIdle, StRun} state_e;

  localparam int unsigned W16    = 16;
  localparam int unsigned W24    = 24;
  localparam int unsigned W32    = 32;
  localparam int unsigned MAX_CH = 8;

  // ws level for a (slot, bit) position; adv looks one bit ahead, giving the Philips advance.
  function automatic logic ws_calc(int unsigned num_ch, int unsigned slot_w, int unsigned slot,
                                   int unsigned bitn, logic adv);
    int unsigned s;
    int unsigned b;
    s = slot;
    b = bitn;
    if (adv) begin
      if (b == slot_w - 1) begin
        b = 32'd0;
        s = (s == num_ch - 1) ? 32'd0 : s + 32'd1;
      end else begin
        b = b + 32'd1;
      end
    end
    return (num_ch == 2) ? (s == 32'd1) : (s == 32'd0 && b == 32'd0);
  endfunction

endpackage

// File: rtl/i2s_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous active-high reset and occupancy.
module i2s_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q;
  logic             push, pop;

  assign full_o    = (level_q == (PtrW + 1)'(Depth));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rptr_q];
  assign push      = wr_en_i & ~full_o;
  assign pop       = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// Multi-channel I2S/TDM transmitter: FIFO-fed, MSB-first, frame-aligned underrun handling.
// Define I2S_TDM_FRAME_CNT_EN to add the frame_cnt output (completed-frame counter).
module i2s_tdm_tx
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        enable,
  input  logic                        standard,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  input  logic                        clr_underrun,
  output logic                        underrun,
  output logic                        busy,
  output logic                        sclk,
  output logic                        ws,
  output logic                        sd
`ifdef I2S_TDM_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_cnt
`endif
);
  localparam int unsigned BitW  = $clog2(SLOT_W);
  localparam int unsigned SlotW = $clog2(NUM_CH);
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  std_t              std_q, std_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              sclk_q, sclk_d, ws_q, ws_d, sd_q, sd_d;
  logic              live_q, live_d, lead_q, lead_d, underrun_q, underrun_d;
  logic              pop, fifo_empty, tc, last_bit, last_slot, frame_ok;
  logic [WORD_W-1:0] head;
  logic              unused_wr_hi;
`ifdef I2S_TDM_FRAME_CNT_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

  assign unused_wr_hi = ^wr_data;

  i2s_sync_fifo #(
    .Width(WORD_W),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (pclk),
    .rst_i    (preset),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_data[WORD_W-1:0]),
    .rd_en_i  (pop),
    .rd_data_o(head),
    .full_o   (full),
    .empty_o  (fifo_empty),
    .level_o  (level)
  );

  assign tc        = (div_q == DivW'(CLK_DIV - 1));
  assign last_bit  = (bit_q == BitW'(SLOT_W - 1));
  assign last_slot = (slot_q == SlotW'(NUM_CH - 1));
  assign frame_ok  = (level >= LvlW'(NUM_CH));

  always_comb begin
    state_d    = state_q;
    std_d      = std_q;
    div_d      = div_q;
    bit_d      = bit_q;
    slot_d     = slot_q;
    sr_d       = sr_q;
    sclk_d     = sclk_q;
    ws_d       = ws_q;
    sd_d       = sd_q;
    live_d     = live_q;
    lead_d     = lead_q;
    underrun_d = clr_underrun ? 1'b0 : underrun_q;
    pop        = 1'b0;
`ifdef I2S_TDM_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        {sclk_d, ws_d, sd_d} = 3'b000;
        div_d  = '0;
        bit_d  = '0;
        slot_d = '0;
        lead_d = 1'b0;
        live_d = 1'b0;
        sr_d   = '0;
        if (enable) begin
          state_d = StRun;
          std_d   = std_t'(standard);
          live_d  = frame_ok;
          pop     = frame_ok;
          sr_d    = frame_ok ? head : '0;
          if (!frame_ok) underrun_d = 1'b1;
          // Philips gets a one-bit lead-in so ws leads the first MSB; the word waits in sr.
          lead_d  = standard;
          sd_d    = standard ? 1'b0 : sr_d[WORD_W-1];
          ws_d    = ws_calc(NUM_CH, SLOT_W, 0, 0, 1'b0);
        end
      end
      StRun: begin
        div_d = tc ? '0 : div_q + 1'b1;
        if (tc) sclk_d = ~sclk_q;
        if (tc && sclk_q) begin
          if (lead_q) begin
            lead_d = 1'b0;
            sd_d   = sr_q[WORD_W-1];
            ws_d   = ws_calc(NUM_CH, SLOT_W, 0, 0, 1'b1);
          end else if (last_bit && last_slot) begin
`ifdef I2S_TDM_FRAME_CNT_EN
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
            bit_d  = '0;
            slot_d = '0;
            if (enable) begin
              live_d = frame_ok;
              pop    = frame_ok;
              sr_d   = frame_ok ? head : '0;
              if (!frame_ok) underrun_d = 1'b1;
              sd_d   = sr_d[WORD_W-1];
              ws_d   = ws_calc(NUM_CH, SLOT_W, 0, 0, std_q == PHILIPS);
            end else begin
              state_d = StIdle;
              live_d  = 1'b0;
              sr_d    = '0;
              ws_d    = 1'b0;
              sd_d    = 1'b0;
            end
          end else begin
            if (last_bit) begin
              bit_d  = '0;
              slot_d = slot_q + 1'b1;
              pop    = live_q & ~fifo_empty;
              sr_d   = live_q ? head : '0;
            end else begin
              bit_d = bit_q + 1'b1;
              sr_d  = sr_q << 1;
            end
            sd_d = sr_d[WORD_W-1];
            ws_d = ws_calc(NUM_CH, SLOT_W, 32'(slot_d), 32'(bit_d), std_q == PHILIPS);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      std_q      <= MSB;
      div_q      <= '0;
      bit_q      <= '0;
      slot_q     <= '0;
      sr_q       <= '0;
      sclk_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      live_q     <= 1'b0;
      lead_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      std_q      <= std_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      sr_q       <= sr_d;
      sclk_q     <= sclk_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      live_q     <= live_d;
      lead_q     <= lead_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef I2S_TDM_FRAME_CNT_EN
  always_ff @(posedge pclk) begin
    if (preset) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`endif

  assign sclk     = sclk_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == StRun);

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: a stereo and a 4-slot TDM instance, streams captured at sclk rises
// and compared against a frame-level model built from the pushed words.
module tb_i2s_tdm_tx;
  import ctrl_pkg::*;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst[2], en[2], stdsel[2], wen[2], clr[2];
  logic [31:0] wd[2];
  logic        full_w[2], und_w[2], busy_w[2], sclk_w[2], ws_w[2], sd_w[2];
  logic [4:0]  lvl_w[2];
`ifdef I2S_TDM_FRAME_CNT_EN
  logic [15:0] fc_w[2];
`endif

  int n_vec, n_err;
  bit cap[2];
  bit qsd0[$], qws0[$], qsd1[$], qws1[$];

  i2s_tdm_tx #(
    .NUM_CH(2), .WORD_W(W32), .SLOT_W(W32), .FIFO_DEPTH(16), .CLK_DIV(2)
  ) u_st (
    .pclk(pclk), .preset(rst[0]), .enable(en[0]), .standard(stdsel[0]), .wr_en(wen[0]),
    .wr_data(wd[0]), .full(full_w[0]), .level(lvl_w[0]), .clr_underrun(clr[0]),
    .underrun(und_w[0]), .busy(busy_w[0]), .sclk(sclk_w[0]), .ws(ws_w[0]), .sd(sd_w[0])
`ifdef I2S_TDM_FRAME_CNT_EN
    , .frame_cnt(fc_w[0])
`endif
  );

  i2s_tdm_tx #(
    .NUM_CH(4), .WORD_W(W24), .SLOT_W(W32), .FIFO_DEPTH(16), .CLK_DIV(2)
  ) u_tdm (
    .pclk(pclk), .preset(rst[1]), .enable(en[1]), .standard(stdsel[1]), .wr_en(wen[1]),
    .wr_data(wd[1]), .full(full_w[1]), .level(lvl_w[1]), .clr_underrun(clr[1]),
    .underrun(und_w[1]), .busy(busy_w[1]), .sclk(sclk_w[1]), .ws(ws_w[1]), .sd(sd_w[1])
`ifdef I2S_TDM_FRAME_CNT_EN
    , .frame_cnt(fc_w[1])
`endif
  );

  always @(posedge sclk_w[0]) begin
    #1;
    if (cap[0]) begin qsd0.push_back(sd_w[0]); qws0.push_back(ws_w[0]); end
  end
  always @(posedge sclk_w[1]) begin
    #1;
    if (cap[1]) begin qsd1.push_back(sd_w[1]); qws1.push_back(ws_w[1]); end
  end

  function automatic int nch(input int d);  return (d == 0) ? 2 : 4;   endfunction
  function automatic int wlen(input int d); return (d == 0) ? 32 : 24; endfunction
  function automatic int qsize(input int d); return (d == 0) ? qsd0.size() : qsd1.size();
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] w);
    wen[d] = 1'b1;
    wd[d]  = w;
    tick();
    wen[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
  endtask

  task automatic clear_q(input int d);
    if (d == 0) begin qsd0.delete(); qws0.delete(); end
    else begin qsd1.delete(); qws1.delete(); end
  endtask

  task automatic get_q(input int d, output bit s[$], output bit w[$]);
    if (d == 0) begin s = qsd0; w = qws0; end
    else begin s = qsd1; w = qws1; end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int k;
    k = 0;
    while (busy_w[d] && k < budget) begin tick(); k++; end
    chk($sformatf("idle%0d_timeout", d), 32'(busy_w[d]), 32'd0);
  endtask

  task automatic wait_samples(input int d, input int n, input int budget);
    int k;
    k = 0;
    while (qsize(d) < n && k < budget) begin tick(); k++; end
    chk($sformatf("samples%0d_reached", d), 32'(qsize(d) >= n), 32'd1);
  endtask

  // Frame-level reference: each live frame carries the next nch words, MSB first, zero-padded;
  // Philips prepends a zero lead-in bit and shifts ws one bit earlier.
  task automatic model(input int nc, input int ww, input bit phil, input bit lives[$],
                       input logic [31:0] words[$], output bit esd[$], output bit ews[$]);
    bit msd[$];
    bit mws[$];
    int k;
    logic [31:0] w;
    k = 0;
    foreach (lives[f]) begin
      for (int s = 0; s < nc; s++) begin
        w = (lives[f] && k < words.size()) ? words[k] : 32'h0;
        for (int b = 0; b < 32; b++) begin
          if (lives[f] && b < ww) msd.push_back(w[ww-1-b]);
          else msd.push_back(1'b0);
          mws.push_back((nc == 2) ? (s == 1) : (s == 0 && b == 0));
        end
        if (lives[f]) k++;
      end
    end
    if (phil) begin
      esd = {1'b0};
      foreach (msd[i]) esd.push_back(msd[i]);
      ews = mws;
      ews.push_back(mws[0]);
    end else begin
      esd = msd;
      ews = mws;
    end
  endtask

  task automatic check_stream(input string name, input bit got[$], input bit exp[$]);
    logic [31:0] g, e;
    chk({name, "_len"}, got.size(), exp.size());
    for (int c = 0; c * 32 < exp.size(); c++) begin
      g = '0;
      e = '0;
      for (int j = 0; j < 32; j++) begin
        if (c * 32 + j < exp.size()) begin
          e[31-j] = exp[c*32+j];
          if (c * 32 + j < got.size()) g[31-j] = got[c*32+j];
        end
      end
      chk($sformatf("%s_chunk%0d", name, c), g, e);
    end
  endtask

  task automatic chk_quiet(input string name, input int d);
    chk(name, {28'd0, sclk_w[d], ws_w[d], sd_w[d], busy_w[d]}, 32'd0);
  endtask

  typedef struct {
    int              d;
    bit              phil;
    int              npush;
    logic [7:0][31:0] w;
    bit              live;
    int              lvl;
    bit              und;
  } vec_t;

  function automatic vec_t mk(input int d, input bit phil, input int npush, input bit live,
                              input int lvl, input bit und);
    vec_t v;
    v.d = d; v.phil = phil; v.npush = npush; v.live = live; v.lvl = lvl; v.und = und;
    for (int i = 0; i < 8; i++) v.w[i] = $urandom;
    return v;
  endfunction

  vec_t tbl[8];

  initial begin
    bit          gs[$], gw[$], es[$], ew[$], lives[$];
    logic [31:0] words[$];
    logic        acc;
    vec_t        v;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; stdsel[i] = 1'b0; wen[i] = 1'b0;
      clr[i] = 1'b0; wd[i] = '0; cap[i] = 1'b0;
    end

    tbl[0] = mk(0, 1'b0, 2, 1'b1, 0, 1'b0);
    tbl[0].w[0] = 32'hA5A50001; tbl[0].w[1] = 32'h5A5A0002;
    tbl[1] = tbl[0];
    tbl[1].phil = 1'b1;
    tbl[2] = mk(1, 1'b0, 4, 1'b1, 0, 1'b0);
    tbl[2].w[0] = 32'h00ABCDEF; tbl[2].w[1] = 32'h00123456;
    tbl[2].w[2] = 32'h00000001; tbl[2].w[3] = 32'h00FFFFFF;
    tbl[3] = mk(1, 1'b0, 3, 1'b0, 3, 1'b1);
    tbl[4] = mk(0, 1'b0, 2, 1'b1, 0, 1'b0);
    tbl[5] = mk(1, 1'b0, 5, 1'b1, 1, 1'b0);
    tbl[6] = mk(0, 1'b1, 3, 1'b1, 1, 1'b0);
    tbl[7] = mk(0, 1'b0, 1, 1'b0, 1, 1'b1);

    // Reset held three cycles with writes attempted.
    wen[0] = 1'b1; wen[1] = 1'b1; wd[0] = 32'h1234; wd[1] = 32'h5678;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_level%0d", d), 32'(lvl_w[d]), 32'd0);
      chk($sformatf("rst_flags%0d", d), {30'd0, full_w[d], und_w[d]}, 32'd0);
      chk_quiet($sformatf("rst_out%0d", d), d);
    end
    rst[0] = 1'b0; rst[1] = 1'b0; wen[0] = 1'b0; wen[1] = 1'b0;
    tick();
    chk("post_rst_level0", 32'(lvl_w[0]), 32'd0);

    // Single-frame vectors.
    foreach (tbl[r]) begin
      v = tbl[r];
      do_reset(v.d);
      words.delete();
      for (int i = 0; i < v.npush; i++) begin
        push(v.d, v.w[i]);
        words.push_back(v.w[i]);
      end
      clear_q(v.d);
      cap[v.d] = 1'b1;
      stdsel[v.d] = v.phil;
      en[v.d] = 1'b1;
      tick();
      en[v.d] = 1'b0;
      wait_idle(v.d, 2000);
      cap[v.d] = 1'b0;
      get_q(v.d, gs, gw);
      lives = {v.live};
      model(nch(v.d), wlen(v.d), v.phil, lives, words, es, ew);
      check_stream($sformatf("v%0d_sd", r), gs, es);
      check_stream($sformatf("v%0d_ws", r), gw, ew);
      chk($sformatf("v%0d_level", r), 32'(lvl_w[v.d]), v.lvl);
      chk($sformatf("v%0d_underrun", r), 32'(und_w[v.d]), 32'(v.und));
      chk_quiet($sformatf("v%0d_idle_out", r), v.d);
    end

    // Underrun, then a live frame once the fourth word arrives.
    do_reset(1);
    words.delete();
    for (int i = 0; i < 3; i++) begin words.push_back($urandom); push(1, words[i]); end
    clear_q(1);
    cap[1] = 1'b1;
    stdsel[1] = 1'b0;
    en[1] = 1'b1;
    repeat (20) tick();
    chk("ur_flag_set", 32'(und_w[1]), 32'd1);
    chk("ur_level3", 32'(lvl_w[1]), 32'd3);
    words.push_back($urandom);
    push(1, words[3]);
    chk("ur_level4", 32'(lvl_w[1]), 32'd4);
    wait_samples(1, 138, 2000);
    en[1] = 1'b0;
    wait_idle(1, 2000);
    cap[1] = 1'b0;
    get_q(1, gs, gw);
    lives = {1'b0, 1'b1};
    model(4, 24, 1'b0, lives, words, es, ew);
    check_stream("ur_sd", gs, es);
    check_stream("ur_ws", gw, ew);
    chk("ur_level0", 32'(lvl_w[1]), 32'd0);
    chk("ur_sticky", 32'(und_w[1]), 32'd1);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("ur_cleared", 32'(und_w[1]), 32'd0);

    // Set wins over a simultaneous clear on the entry cycle.
    do_reset(1);
    clr[1] = 1'b1;
    en[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    en[1] = 1'b0;
    chk("ur_set_priority", 32'(und_w[1]), 32'd1);
    wait_idle(1, 2000);

    // Overfill, stop mid-frame at slot 1 bit 10, then hold quiet.
    do_reset(0);
    words.delete();
    for (int i = 0; i < 18; i++) begin words.push_back($urandom); push(0, words[i]); end
    chk("full_flag", 32'(full_w[0]), 32'd1);
    chk("full_level", 32'(lvl_w[0]), 32'd16);
    clear_q(0);
    cap[0] = 1'b1;
    stdsel[0] = 1'b0;
    en[0] = 1'b1;
    tick();
    wait_samples(0, 43, 1000);
    en[0] = 1'b0;
    wait_idle(0, 1000);
    cap[0] = 1'b0;
    get_q(0, gs, gw);
    lives = {1'b1};
    model(2, 32, 1'b0, lives, words, es, ew);
    check_stream("stop_sd", gs, es);
    check_stream("stop_ws", gw, ew);
    chk("stop_level", 32'(lvl_w[0]), 32'd14);
    chk("stop_full", 32'(full_w[0]), 32'd0);
    acc = 1'b0;
    repeat (40) begin
      tick();
      acc = acc | sclk_w[0] | ws_w[0] | sd_w[0] | busy_w[0];
    end
    chk("stop_held_quiet", 32'(acc), 32'd0);

    // Reset in the middle of a frame aborts it and empties the FIFO.
    en[0] = 1'b1;
    repeat (100) tick();
    chk("abort_busy_before", 32'(busy_w[0]), 32'd1);
    en[0] = 1'b0;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk_quiet("abort_out", 0);
    chk("abort_level", 32'(lvl_w[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
